router_sync: RTL and testbench
==============================

// Module: router_sync
// PURPOSE
//   Synchronizer/steering stage between router FSM/register and the three
//   router_fifo instances of the 3x1 router. Latches destination address from
//   the header byte and steers the write strobe to one FIFO. Exports per-port
//   valid flags and the selected FIFO's full flag. Issues a one-cycle
//   soft_rst to any FIFO whose data sits unread for TIMEOUT cycles.
// PARAMETERS
//   TIMEOUT  30  consecutive valid-but-unread cycles before soft_rst_x pulses
//   CNT_W    5   timeout counter width; requires 2**CNT_W >= TIMEOUT
// PORTS
//   clk            in   1  system clock, all state on posedge
//   rst            in   1  synchronous reset, active-high
//   detect_add     in   1  header cycle: latch data_in as destination address
//   data_in        in   2  destination address (0,1,2 valid; 3 = invalid)
//   write_enb_reg  in   1  FSM request to write current byte to dest FIFO
//   rd_en_0..2     in   1  downstream read enable of FIFO 0/1/2
//   empty_0..2     in   1  empty flag of FIFO 0/1/2
//   full_0..2      in   1  full flag of FIFO 0/1/2
//   write_enb      out  3  one-hot wr_en to FIFOs, bit x drives FIFO x
//   fifo_full      out  1  full flag of currently addressed FIFO
//   vld_out_0..2   out  1  FIFO x holds data (= ~empty_x)
//   soft_rst_0..2  out  1  registered one-cycle soft reset to FIFO x
// BEHAVIOUR
//   - Reset (rst=1 at posedge): addr_q<=2'b11, cnt_0..2<=0, soft_rst_0..2<=0.
//     Combinational outputs keep following inputs during reset.
//   - addr_sel = detect_add ? data_in : addr_q (header routes in same cycle).
//     On posedge with detect_add=1, addr_q<=data_in; else addr_q holds.
//   - write_enb = write_enb_reg ? onehot(addr_sel) : 3'b000; addr_sel=3 gives
//     3'b000 (byte dropped). Zero latency, combinational.
//   - fifo_full = full_[addr_sel]; 0 when addr_sel=3. Combinational.
//   - vld_out_x = ~empty_x, combinational, no latency.
//   - Per-port timeout, independent for x=0,1,2: qualify_x = vld_out_x & ~rd_en_x.
//     posedge, qualify_x=0: cnt_x<=0, soft_rst_x<=0.
//     posedge, qualify_x=1, cnt_x<TIMEOUT-1: cnt_x<=cnt_x+1, soft_rst_x<=0.
//     posedge, qualify_x=1, cnt_x==TIMEOUT-1: cnt_x<=0, soft_rst_x<=1.
//     soft_rst_x is high for exactly the cycle after the TIMEOUT-th
//     consecutive qualifying cycle, never two cycles in a row. Counting
//     restarts if data remains.
//   - Any single read (rd_en_x=1) or empty FIFO clears cnt_x. No partial credit.
//   - detect_add while write_enb_reg=1 of the old packet: the new address wins
//     that cycle (FSM never does this legally; the behaviour is defined anyway).
//   - Counters never wrap. cnt_x <= TIMEOUT-1 always.
//   - rst mid-timeout: counter and pending soft_rst cleared on that edge.
// CONFIGURATION
//   ROUTER_SYNC_STAT_EN defined: extra output timeout_evt [7:0], reset 0,
//     increments once per posedge on which any soft_rst_x is set (max +1 per
//     cycle even if several ports time out together), saturates at 8'hFF.
//   Not defined: port and logic absent; other behaviour identical.
// TESTING
//   1 rst=1 two cycles -> write_enb=0, soft_rst_*=0, fifo_full=0 (addr_q=3).
//   2 detect_add=1,data_in=2,write_enb_reg=1 -> write_enb=3'b100 same cycle;
//     next cycles with detect_add=0 keep 3'b100; full_2=1 -> fifo_full=1.
//   3 data_in=3 header, write_enb_reg=1 -> write_enb=3'b000, fifo_full=0.
//   4 empty_1=0,rd_en_1=0 held from cycle 0 -> soft_rst_1 high only in
//     cycle 30, low in 29 and 31; soft_rst_0/2 stay 0.
//   5 empty_0=0, rd_en_0 pulsed at cycle 20 -> no soft_rst_0 at cycle 30;
//     pulse appears at cycle 51.
//   6 ports 0 and 2 time out in the same cycle with ROUTER_SYNC_STAT_EN
//     -> timeout_evt 0->1. Force 300 events -> saturates at 8'hFF.

Source files
------------

// File: rtl/router_sync.sv
// router_sync: address latch, write steering and per-FIFO read timeout.
// Ports: clk/rst; detect_add, data_in, write_enb_reg, rd_en_0..2, empty_0..2,
// full_0..2 in; write_enb[2:0], fifo_full, vld_out_0..2, soft_rst_0..2 out.
// Optional ROUTER_SYNC_STAT_EN adds timeout_evt[7:0], a saturating count of
// cycles in which at least one FIFO timed out.
module router_sync #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       rd_en_0,
  input  logic       rd_en_1,
  input  logic       rd_en_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
`ifdef ROUTER_SYNC_STAT_EN
  output logic [7:0] timeout_evt,
`endif
  output logic       soft_rst_0,
  output logic       soft_rst_1,
  output logic       soft_rst_2
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       addr_q;
  logic [1:0]       addr_sel;
  logic [2:0]       empty_v;
  logic [2:0]       rd_v;
  logic [2:0]       full_v;
  logic [2:0]       qualify;
  logic [2:0]       expire;
  logic [2:0]       soft_q;
  logic [CNT_W-1:0] cnt [3];

  assign empty_v = {empty_2, empty_1, empty_0};
  assign rd_v    = {rd_en_2, rd_en_1, rd_en_0};
  assign full_v  = {full_2, full_1, full_0};

  assign vld_out_0 = ~empty_0;
  assign vld_out_1 = ~empty_1;
  assign vld_out_2 = ~empty_2;

  assign soft_rst_0 = soft_q[0];
  assign soft_rst_1 = soft_q[1];
  assign soft_rst_2 = soft_q[2];

  // A header routes its own cycle, before addr_q has captured it.
  assign addr_sel = detect_add ? data_in : addr_q;

  always_comb begin
    write_enb = 3'b000;
    fifo_full = 1'b0;
    case (addr_sel)
      2'd0: begin
        write_enb = {2'b00, write_enb_reg};
        fifo_full = full_v[0];
      end
      2'd1: begin
        write_enb = {1'b0, write_enb_reg, 1'b0};
        fifo_full = full_v[1];
      end
      2'd2: begin
        write_enb = {write_enb_reg, 2'b00};
        fifo_full = full_v[2];
      end
      default: begin
        write_enb = 3'b000;
        fifo_full = 1'b0;
      end
    endcase
  end

  always_comb begin
    qualify = ~empty_v & ~rd_v;
    expire  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      expire[i] = qualify[i] && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= 2'b11;
    end else if (detect_add) begin
      addr_q <= data_in;
    end
  end

  // Any read or an empty FIFO restarts the wait from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
      soft_q <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!qualify[i] || expire[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
      soft_q <= expire;
    end
  end

`ifdef ROUTER_SYNC_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_evt <= 8'h00;
    end else if (|expire && timeout_evt != 8'hFF) begin
      timeout_evt <= timeout_evt + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_router_sync.sv
// tb_router_sync: directed checks of steering, valid flags and timeouts.
// One task per scenario; summary line reports errors and total checks.
module tb_router_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic       rd_en_0, rd_en_1, rd_en_2;
  logic       empty_0, empty_1, empty_2;
  logic       full_0, full_1, full_2;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_rst_0, soft_rst_1, soft_rst_2;
`ifdef ROUTER_SYNC_STAT_EN
  logic [7:0] timeout_evt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  router_sync dut (
    .clk          (clk),
    .rst          (rst),
    .detect_add   (detect_add),
    .data_in      (data_in),
    .write_enb_reg(write_enb_reg),
    .rd_en_0      (rd_en_0),
    .rd_en_1      (rd_en_1),
    .rd_en_2      (rd_en_2),
    .empty_0      (empty_0),
    .empty_1      (empty_1),
    .empty_2      (empty_2),
    .full_0       (full_0),
    .full_1       (full_1),
    .full_2       (full_2),
    .write_enb    (write_enb),
    .fifo_full    (fifo_full),
    .vld_out_0    (vld_out_0),
    .vld_out_1    (vld_out_1),
    .vld_out_2    (vld_out_2),
`ifdef ROUTER_SYNC_STAT_EN
    .timeout_evt  (timeout_evt),
`endif
    .soft_rst_0   (soft_rst_0),
    .soft_rst_1   (soft_rst_1),
    .soft_rst_2   (soft_rst_2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    detect_add    = 1'b0;
    data_in       = 2'd0;
    write_enb_reg = 1'b0;
    {rd_en_2, rd_en_1, rd_en_0} = 3'b000;
    {empty_2, empty_1, empty_0} = 3'b111;
    {full_2, full_1, full_0}    = 3'b000;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    write_enb_reg = 1'b1;
    {full_2, full_1, full_0} = 3'b111;
    rst = 1'b1;
    step();
    step();
    checks++;
    if (write_enb !== 3'b000) begin
      errors++;
      $display("FAIL reset_write_enb got=%b exp=000", write_enb);
    end
    checks++;
    if (fifo_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_fifo_full got=%b exp=0", fifo_full);
    end
    checks++;
    if ({soft_rst_2, soft_rst_1, soft_rst_0} !== 3'b000) begin
      errors++;
      $display("FAIL reset_soft_rst got=%b exp=000",
               {soft_rst_2, soft_rst_1, soft_rst_0});
    end
    empty_1 = 1'b0;
    #1;
    checks++;
    if ({vld_out_2, vld_out_1, vld_out_0} !== 3'b010) begin
      errors++;
      $display("FAIL reset_vld_comb got=%b exp=010",
               {vld_out_2, vld_out_1, vld_out_0});
    end
    rst = 1'b0;
    idle_inputs();
    step();
  endtask

  task automatic test_steer();
    detect_add    = 1'b1;
    data_in       = 2'd2;
    write_enb_reg = 1'b1;
    #1;
    checks++;
    if (write_enb !== 3'b100) begin
      errors++;
      $display("FAIL steer_header got=%b exp=100", write_enb);
    end
    step();
    detect_add = 1'b0;
    data_in    = 2'd0;
    #1;
    checks++;
    if (write_enb !== 3'b100) begin
      errors++;
      $display("FAIL steer_hold got=%b exp=100", write_enb);
    end
    {full_2, full_1, full_0} = 3'b011;
    #1;
    checks++;
    if (fifo_full !== 1'b0) begin
      errors++;
      $display("FAIL steer_full_other got=%b exp=0", fifo_full);
    end
    full_2 = 1'b1;
    #1;
    checks++;
    if (fifo_full !== 1'b1) begin
      errors++;
      $display("FAIL steer_full_sel got=%b exp=1", fifo_full);
    end
    write_enb_reg = 1'b0;
    #1;
    checks++;
    if (write_enb !== 3'b000) begin
      errors++;
      $display("FAIL steer_no_req got=%b exp=000", write_enb);
    end
    write_enb_reg = 1'b1;
    detect_add    = 1'b1;
    data_in       = 2'd0;
    #1;
    checks++;
    if (write_enb !== 3'b001) begin
      errors++;
      $display("FAIL steer_new_addr_wins got=%b exp=001", write_enb);
    end
    step();
    detect_add = 1'b0;
    data_in    = 2'd1;
    #1;
    checks++;
    if (write_enb !== 3'b001) begin
      errors++;
      $display("FAIL steer_latched0 got=%b exp=001", write_enb);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_invalid_addr();
    {full_2, full_1, full_0} = 3'b111;
    detect_add    = 1'b1;
    data_in       = 2'd3;
    write_enb_reg = 1'b1;
    #1;
    checks++;
    if (write_enb !== 3'b000 || fifo_full !== 1'b0) begin
      errors++;
      $display("FAIL invalid_header got=%b/%b exp=000/0",
               write_enb, fifo_full);
    end
    step();
    detect_add = 1'b0;
    data_in    = 2'd1;
    #1;
    checks++;
    if (write_enb !== 3'b000 || fifo_full !== 1'b0) begin
      errors++;
      $display("FAIL invalid_latched got=%b/%b exp=000/0",
               write_enb, fifo_full);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_timeout_hold();
    bit exp;
    do_reset();
    empty_1 = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      step();
      exp = (k == 30);
      checks++;
      if (soft_rst_1 !== exp) begin
        errors++;
        $display("FAIL hold_soft_rst_1 cyc=%0d got=%b exp=%b",
                 k, soft_rst_1, exp);
      end
      checks++;
      if (soft_rst_0 !== 1'b0 || soft_rst_2 !== 1'b0) begin
        errors++;
        $display("FAIL hold_other_ports cyc=%0d got=%b%b exp=00",
                 k, soft_rst_2, soft_rst_0);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_timeout_read();
    bit exp;
    do_reset();
    empty_0 = 1'b0;
    for (int k = 1; k <= 52; k++) begin
      step();
      rd_en_0 = (k == 20);
      exp = (k == 51);
      checks++;
      if (soft_rst_0 !== exp) begin
        errors++;
        $display("FAIL read_soft_rst_0 cyc=%0d got=%b exp=%b",
                 k, soft_rst_0, exp);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    empty_2 = 1'b0;
    repeat (29) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (soft_rst_2 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_pending got=%b exp=0", soft_rst_2);
    end
    repeat (29) step();
    checks++;
    if (soft_rst_2 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_cnt29 got=%b exp=0", soft_rst_2);
    end
    step();
    checks++;
    if (soft_rst_2 !== 1'b1) begin
      errors++;
      $display("FAIL midrst_cnt30 got=%b exp=1", soft_rst_2);
    end
    idle_inputs();
    step();
  endtask

`ifdef ROUTER_SYNC_STAT_EN
  task automatic test_stat();
    do_reset();
    checks++;
    if (timeout_evt !== 8'h00) begin
      errors++;
      $display("FAIL stat_reset got=%0h exp=00", timeout_evt);
    end
    empty_0 = 1'b0;
    empty_2 = 1'b0;
    repeat (29) step();
    checks++;
    if (timeout_evt !== 8'h00) begin
      errors++;
      $display("FAIL stat_before got=%0h exp=00", timeout_evt);
    end
    step();
    checks++;
    if (timeout_evt !== 8'h01 || soft_rst_0 !== 1'b1 || soft_rst_2 !== 1'b1) begin
      errors++;
      $display("FAIL stat_dual got=%0h exp=01", timeout_evt);
    end
    repeat (299 * 30) step();
    checks++;
    if (timeout_evt !== 8'hFF) begin
      errors++;
      $display("FAIL stat_saturate got=%0h exp=ff", timeout_evt);
    end
    idle_inputs();
    step();
  endtask
`endif

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_steer();
    test_invalid_addr();
    test_timeout_hold();
    test_timeout_read();
    test_reset_mid();
`ifdef ROUTER_SYNC_STAT_EN
    test_stat();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
